game_timer: RTL and testbench

- Elapsed-time source for the game datapath; produces the 7-bit seconds count that the score stage converts into points.
- Runs a clock prescaler to generate a 1 s tick and counts whole seconds from start until the player stops or the limit is reached.
- Freezes the final time so downstream scoring and 7-segment display see a stable value.
- Also exports BCD digits of the count for the display driver.

---
 rtl/game_timer.sv | 147 ++++++++++++++
 tb/tb_game_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Game elapsed-time counter.
// A prescaler produces a one-second tick. Whole seconds are counted from start
// until stop or the time limit, and the final value is frozen for scoring and
// display. BCD digits of the count are kept in step with the binary count.
module game_timer #(
  parameter int TICK_DIV = 1_000_000,  // clock cycles per second, >= 2
  parameter int MAX_TIME = 90          // time limit in seconds, <= 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic [6:0] time_count,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       timeout,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    COUNT_LAST = 7'(MAX_TIME);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [6:0]    count_reg, count_next;
  logic [3:0]    tens_reg, tens_next;
  logic [3:0]    ones_reg, ones_next;
  logic          running_reg, running_next;
  logic          done_reg, done_next;
  logic          timeout_reg, timeout_next;
  logic          tick_reg, tick_next;

  // Next-state and next-output logic; input priority is stop > pause > start.
  always_comb begin
    state_next   = state_reg;
    presc_next   = presc_reg;
    count_next   = count_reg;
    tens_next    = tens_reg;
    ones_next    = ones_reg;
    timeout_next = timeout_reg;
    tick_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUNNING;
          presc_next = '0;
          count_next = '0;
          tens_next  = '0;
          ones_next  = '0;
        end
      end

      RUNNING: begin
        if (stop) begin
          // Stop beats a coinciding prescaler wrap: no increment, no tick.
          state_next   = DONE;
          timeout_next = 1'b0;
        end else if (pause) begin
          // Prescaler is held so the partial second survives the pause.
          state_next = PAUSED;
        end else if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          count_next = count_reg + 7'd1;
          tick_next  = 1'b1;
          if (ones_reg == 4'd9) begin
            ones_next = 4'd0;
            tens_next = tens_reg + 4'd1;
          end else begin
            ones_next = ones_reg + 4'd1;
          end
          if (count_next == COUNT_LAST) begin
            state_next   = DONE;
            timeout_next = 1'b1;
          end
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end

      PAUSED: begin
        if (stop) begin
          state_next   = DONE;
          timeout_next = 1'b0;
        end else if (pause) begin
          state_next = RUNNING;
        end
      end

      DONE: begin
        if (start) begin
          state_next   = RUNNING;
          presc_next   = '0;
          count_next   = '0;
          tens_next    = '0;
          ones_next    = '0;
          timeout_next = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase

    running_next = (state_next == RUNNING);
    done_next    = (state_next == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      count_reg   <= '0;
      tens_reg    <= '0;
      ones_reg    <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      count_reg   <= count_next;
      tens_reg    <= tens_next;
      ones_reg    <= ones_next;
      running_reg <= running_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      tick_reg    <= tick_next;
    end
  end

  assign time_count = count_reg;
  assign tens       = tens_reg;
  assign ones       = ones_reg;
  assign running    = running_reg;
  assign done       = done_reg;
  assign timeout    = timeout_reg;
  assign tick       = tick_reg;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed scenarios plus random pulses,
// checked every cycle against a model that counts accumulated running cycles.
module tb_game_timer;

  localparam int TICK = 4;
  localparam int MAXT = 90;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] time_count;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       timeout;
  logic       tick;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: mode, running cycles accumulated this run, timeout, tick.
  int m_mode = M_IDLE;
  int m_acc  = 0;
  bit m_timeout = 1'b0;
  bit m_tick = 1'b0;

  game_timer #(.TICK_DIV(TICK), .MAX_TIME(MAXT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .time_count(time_count), .tens(tens), .ones(ones),
    .running(running), .done(done), .timeout(timeout), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    return m_acc / TICK;
  endfunction

  // Model: elapsed seconds are accumulated running cycles divided by TICK.
  always @(posedge clk) begin
    m_tick = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_acc = 0; m_timeout = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_RUN; m_acc = 0; end
        M_RUN: begin
          if (stop) begin
            m_mode = M_DONE; m_timeout = 1'b0;
          end else if (pause) begin
            m_mode = M_PAUSE;
          end else begin
            m_acc++;
            if (m_acc % TICK == 0) begin
              m_tick = 1'b1;
              if (m_count() == MAXT) begin m_mode = M_DONE; m_timeout = 1'b1; end
            end
          end
        end
        M_PAUSE: begin
          if (stop) begin m_mode = M_DONE; m_timeout = 1'b0; end
          else if (pause) m_mode = M_RUN;
        end
        default: if (start) begin m_mode = M_RUN; m_acc = 0; m_timeout = 1'b0; end
      endcase
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic [18:0] act, exp;
    if (cmp_en) begin
      act = {time_count, tens, ones, running, done, timeout, tick};
      exp = {7'(m_count()), 4'(m_count() / 10), 4'(m_count() % 10),
             m_mode == M_RUN, m_mode == M_DONE, m_timeout, m_tick};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_model t=%0t got cnt=%0d tens=%0d ones=%0d run=%b done=%b to=%b tick=%b want cnt=%0d tens=%0d ones=%0d run=%b done=%b to=%b tick=%b",
                 $time, act[18:12], act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                 exp[18:12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic cyc(input bit r, input bit st, input bit sp, input bit pa);
    rst = r; start = st; stop = sp; pause = pa;
    @(posedge clk);
    #1;
    rst = 0; start = 0; stop = 0; pause = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic run_until(input int target, input int bound, input string name);
    int n = 0;
    while (m_count() != target && n < bound) begin
      idle(1);
      n++;
    end
    chk(name, int'(time_count), target);
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({time_count, tens, ones, running, done, timeout, tick}), 0);
  endtask

  initial begin
    #1;
    // 1. Reset then start.
    cyc(1, 0, 0, 0);
    cmp_en = 1'b1;
    chk_zero("reset_state");
    cyc(0, 1, 0, 0);
    chk("start_running", int'(running), 1);
    idle(3);
    chk("pre_tick_count", int'(time_count), 0);
    idle(1);
    chk("first_tick", int'(tick), 1);
    chk("first_count", int'(time_count), 1);
    idle(4);
    chk("second_count", int'(time_count), 2);
    chk("second_ones", int'(ones), 2);
    $display("scenario1 count=%0d tens=%0d ones=%0d", time_count, tens, ones);

    // 2. Run to the limit.
    run_until(10, 100, "reach_10");
    chk("ten_tens", int'(tens), 1);
    chk("ten_ones", int'(ones), 0);
    run_until(90, 400, "reach_limit");
    chk("limit_done", int'(done), 1);
    chk("limit_timeout", int'(timeout), 1);
    chk("limit_running", int'(running), 0);
    idle(25);
    chk("limit_hold", int'(time_count), 90);
    $display("scenario2 count=%0d done=%0b timeout=%0b", time_count, done, timeout);

    // 3. Restart from DONE, stop at 37.
    cyc(0, 1, 0, 0);
    chk("restart_count", int'(time_count), 0);
    chk("restart_timeout", int'(timeout), 0);
    run_until(37, 200, "reach_37");
    cyc(0, 0, 1, 0);
    chk("stop37_done", int'(done), 1);
    chk("stop37_timeout", int'(timeout), 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    idle(6);
    chk("stop37_count", int'(time_count), 37);
    chk("stop37_tens", int'(tens), 3);
    chk("stop37_ones", int'(ones), 7);
    $display("scenario3 count=%0d tens=%0d ones=%0d", time_count, tens, ones);

    // 4. Pause two prescaler cycles into second 5.
    cyc(0, 1, 0, 0);
    run_until(5, 40, "reach_5");
    idle(2);
    cyc(0, 0, 0, 1);
    chk("paused_running", int'(running), 0);
    idle(50);
    chk("paused_hold", int'(time_count), 5);
    cyc(0, 0, 0, 1);
    chk("resume_running", int'(running), 1);
    idle(1);
    chk("resume_plus1", int'(time_count), 5);
    idle(1);
    chk("resume_plus2", int'(time_count), 6);
    chk("resume_tick", int'(tick), 1);
    $display("scenario4 count=%0d after resume", time_count);

    // 5. Stop coinciding with the wrap at 12; stop+pause together.
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    run_until(12, 80, "reach_12");
    idle(3);
    cyc(0, 0, 1, 0);
    chk("wrapstop_count", int'(time_count), 12);
    chk("wrapstop_tick", int'(tick), 0);
    chk("wrapstop_done", int'(done), 1);
    cyc(0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 1, 1);
    chk("stoppause_done", int'(done), 1);
    chk("stoppause_running", int'(running), 0);
    $display("scenario5 count=%0d done=%0b", time_count, done);

    // 6. Reset mid-run, and reset overriding start.
    cyc(0, 1, 0, 0);
    run_until(45, 250, "reach_45");
    cyc(1, 0, 0, 0);
    chk_zero("midrun_reset");
    cyc(1, 1, 0, 0);
    chk_zero("reset_over_start");
    $display("scenario6 count=%0d running=%0b", time_count, running);

    // Random pulses checked by the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 69) == 0, $urandom_range(0, 24) == 0);
    end
    $display("random phase final count=%0d mode=%0d", time_count, m_mode);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
